alu_req_arbiter: RTL and testbench
==================================

# alu_req_arbiter

Two-requester arbiter and sequencer for the registered 8/16-bit arithmetic unit. It accepts operation requests from two clients and grants them round-robin. It drives the unit's operand, function and enable inputs for exactly one cycle per operation, captures the registered result, and returns it to the granted client through a valid/ready response port. It sits between the client logic and the arithmetic unit, which it owns exclusively.

## Interface
- in_width, 8, operand width (must match the arithmetic unit)
- out_width, 16, result width (must match the arithmetic unit)

- clk  input  1  clock
- RST  input  1  reset, asynchronous, active-low
- req0_valid / req1_valid  input  1  client request pending
- req0_A, req0_B / req1_A, req1_B  input  in_width  operands
- req0_fun / req1_fun  input  2  function: 00 add, 01 sub, 10 mul, 11 div
- req0_ready / req1_ready  output  1  request accepted this cycle (valid&ready = handshake)
- alu_A, alu_B  output  in_width  to arithmetic unit
- alu_fun  output  2  to arithmetic unit ALU_FUN
- alu_enable  output  1  to arithmetic unit Arith_Enable
- alu_out  input  out_width  from Arith_OUT
- alu_carry  input  1  from Carry_OUT
- alu_flag  input  1  from Arith_Flag
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  client that issued the op (0/1)
- rsp_out  output  out_width  captured result
- rsp_carry  output  1  captured carry
- rsp_err  output  1  op was divide with B==0
- busy  output  1  state != IDLE

## Operation
- FSM states IDLE, ISSUE, CAPTURE, RESP. Reset state IDLE.
- IDLE:
  - Compute a grant if any reqN_valid. A single valid client wins.
  - If both are valid, the client != last_grant wins. last_grant resets to 1, so client 0 wins first.
  - reqN_ready = (state==IDLE) & grantN. This is combinational, at most one high, and never high outside IDLE.
  - On handshake: latch A, B, fun and id into the op registers. Set err = (fun==11 && B==0). Update last_grant to id. Go to ISSUE.
- ISSUE: alu_enable=1, and alu_A/alu_B/alu_fun carry the op registers. Go to CAPTURE.
- CAPTURE:
  - alu_enable=0.
  - Latch alu_out into rsp_out and alu_carry into rsp_carry. Latch err into rsp_err.
  - If alu_flag==0, set rsp_err=1 as well. This is a sequencing fault and cannot occur in correct operation.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_out, rsp_carry and rsp_err are held stable.
  - Go to IDLE on rsp_ready. Otherwise stay, for any number of cycles.
- Division by zero: the result the unit returns (all ones in the low out_width bits, carry 1) is passed through unchanged, with rsp_err=1.
- alu_A, alu_B and alu_fun always drive the op registers. They are don't-care while alu_enable=0.
- No request is dropped. A client whose valid is low at grant time loses no state, and a client that is not granted simply waits.
- Clients hold valid and operands stable until they see ready.

## Timing
- Reset values: all outputs 0 (reqN_ready 0, alu_* 0, alu_enable 0, rsp_* 0, busy 0), op registers 0, last_grant 1, state IDLE.
- Latency with rsp_ready held high:
  - Handshake in cycle T.
  - alu_enable high during T+1.
  - Result captured at the end of T+2.
  - rsp_valid high in T+3.
  - Next handshake possible no earlier than T+4.
- Peak throughput is 1 op per 4 cycles.
- rsp_ready sampled only in RESP. A rsp_ready level in other states has no effect.
- Simultaneous requests in IDLE: strict alternation. Back-to-back contention yields grants 0,1,0,1…
- A requester that drops valid before ready is not served, and no state changes.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - The in-flight op and its response are discarded, and alu_enable falls at once.
  - After release, the next grant goes to client 0.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset: drive outputs to X-free values, assert RST low for 2 cycles -> all outputs 0, busy 0. Then req1 only (A=5, B=3, fun=00) -> req1_ready in the first IDLE cycle; rsp_valid at T+3 with rsp_id=1, rsp_out=8, rsp_carry=0, rsp_err=0.
- Contention: req0 (A=200, B=100, fun=00) and req1 (A=12, B=12, fun=10) both held valid -> grants alternate 0,1,0. Responses are (id0, rsp_out=0x012C) then (id1, rsp_out=0x0090), with no duplicate or lost op.
- Divide by zero: req0 A=9, B=0, fun=11 -> rsp_err=1, rsp_id=0, and rsp_out/rsp_carry equal the unit's output. A following req0 A=9, B=2, fun=11 -> rsp_out=4, rsp_err=0.
- Backpressure: complete an op with rsp_ready=0 for 10 cycles -> rsp_valid and data stay stable, alu_enable stays 0, and both reqN_ready stay 0. Raising rsp_ready -> IDLE on the next cycle.
- Reset mid-op: assert RST in the ISSUE cycle -> alu_enable and busy drop immediately and no response appears. After release, a simultaneous req0/req1 grants client 0.
- Subtract underflow: req1 A=3, B=5, fun=01 -> rsp_out=0xFFFE, rsp_carry=1, and exactly one alu_enable pulse is observed per op.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter_if
// Description : Bundle of the two client request ports, the arithmetic-unit
//               drive/return signals and the response port of the ALU
//               request arbiter. The slave view belongs to the arbiter; the
//               master view belongs to the surrounding clients and the
//               arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_req_arbiter_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
);

  // Client 0 request
  logic                 req0_valid;
  logic [IN_WIDTH-1:0]  req0_A;
  logic [IN_WIDTH-1:0]  req0_B;
  logic [1:0]           req0_fun;
  logic                 req0_ready;

  // Client 1 request
  logic                 req1_valid;
  logic [IN_WIDTH-1:0]  req1_A;
  logic [IN_WIDTH-1:0]  req1_B;
  logic [1:0]           req1_fun;
  logic                 req1_ready;

  // Arithmetic unit side
  logic [IN_WIDTH-1:0]  alu_A;
  logic [IN_WIDTH-1:0]  alu_B;
  logic [1:0]           alu_fun;
  logic                 alu_enable;
  logic [OUT_WIDTH-1:0] alu_out;
  logic                 alu_carry;
  logic                 alu_flag;

  // Response port
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [OUT_WIDTH-1:0] rsp_out;
  logic                 rsp_carry;
  logic                 rsp_err;

  // Status
  logic                 busy;

  // Arbiter view
  modport slave (
    input  req0_valid, req0_A, req0_B, req0_fun,
    input  req1_valid, req1_A, req1_B, req1_fun,
    input  alu_out, alu_carry, alu_flag,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output alu_A, alu_B, alu_fun, alu_enable,
    output rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_err,
    output busy
  );

  // Client / arithmetic-unit view
  modport master (
    output req0_valid, req0_A, req0_B, req0_fun,
    output req1_valid, req1_A, req1_B, req1_fun,
    output alu_out, alu_carry, alu_flag,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_A, alu_B, alu_fun, alu_enable,
    input  rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_err,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter and sequencer for two clients sharing a
//               registered 8/16-bit arithmetic unit. Each accepted request is
//               issued to the unit for exactly one cycle, its registered
//               result is captured, and it is returned to the issuing client
//               through a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             RST,
  alu_req_arbiter_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants and state encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_fun_div = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  // Round-robin history: id of the most recently granted client.
  // Resets to 1 so that client 0 wins the first contended grant.
  logic                 r_last_grant;

  // Operation registers, loaded on the request handshake
  logic [IN_WIDTH-1:0]  r_op_a;
  logic [IN_WIDTH-1:0]  r_op_b;
  logic [1:0]           r_op_fun;
  logic                 r_op_id;
  logic                 r_op_err;

  // Response registers, loaded in CAPTURE
  logic [OUT_WIDTH-1:0] r_rsp_out;
  logic                 r_rsp_carry;
  logic                 r_rsp_err;

  // Grant decode
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_accept;
  logic [IN_WIDTH-1:0]  w_sel_a;
  logic [IN_WIDTH-1:0]  w_sel_b;
  logic [1:0]           w_sel_fun;
  logic                 w_sel_div0;

  // --------------------------------------------------------------------------
  // Grant selection: a lone requester wins outright; on contention the client
  // that was not granted last time wins, giving strict alternation.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant0 = bus.req0_valid & (~bus.req1_valid |  r_last_grant);
    w_grant1 = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  end

  // Handshake can only happen in IDLE; grants are mutually exclusive so a
  // simple mux on w_grant1 picks the winning operands.
  assign w_accept   = (r_state == ST_IDLE) & (w_grant0 | w_grant1);
  assign w_sel_a    = w_grant1 ? bus.req1_A   : bus.req0_A;
  assign w_sel_b    = w_grant1 ? bus.req1_B   : bus.req0_B;
  assign w_sel_fun  = w_grant1 ? bus.req1_fun : bus.req0_fun;
  assign w_sel_div0 = (w_sel_fun == c_fun_div) && (w_sel_b == '0);

  // --------------------------------------------------------------------------
  // State register; reset drops every in-flight operation immediately
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.alu_enable = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req0_ready = w_grant0;
        bus.req1_ready = w_grant1;
        if (w_grant0 | w_grant1) begin
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The unit sees exactly one enable cycle per accepted operation
        bus.alu_enable = 1'b1;
        w_next_state   = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Operation registers and round-robin history, loaded on handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_fun     <= 2'b00;
      r_op_id      <= 1'b0;
      r_op_err     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_op_a       <= w_sel_a;
      r_op_b       <= w_sel_b;
      r_op_fun     <= w_sel_fun;
      r_op_id      <= w_grant1;
      r_op_err     <= w_sel_div0;
      r_last_grant <= w_grant1;
    end
  end

  // --------------------------------------------------------------------------
  // Result capture one cycle after the enable pulse. A missing result flag at
  // this point means the unit and the sequencer disagree on timing, which is
  // reported through rsp_err rather than silently returning stale data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_rsp_out   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == ST_CAPTURE) begin
      r_rsp_out   <= bus.alu_out;
      r_rsp_carry <= bus.alu_carry;
      r_rsp_err   <= r_op_err | ~bus.alu_flag;
    end
  end

  // --------------------------------------------------------------------------
  // Output drive: the unit always sees the op registers (don't-care while the
  // enable is low); response fields are held in registers throughout RESP.
  // --------------------------------------------------------------------------
  assign bus.alu_A     = r_op_a;
  assign bus.alu_B     = r_op_b;
  assign bus.alu_fun   = r_op_fun;
  assign bus.rsp_id    = r_op_id;
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_carry = r_rsp_carry;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Directed self-checking bench for alu_req_arbiter, including a
//               behavioural model of the registered arithmetic unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_arbiter;

  localparam int c_IN_WIDTH  = 8;
  localparam int c_OUT_WIDTH = 16;

  logic clk = 1'b0;
  logic RST;
  int   checks   = 0;
  int   errors   = 0;
  int   en_count = 0;
  int   en_snap;

  alu_req_arbiter_if #(.IN_WIDTH(c_IN_WIDTH), .OUT_WIDTH(c_OUT_WIDTH)) bus ();

  alu_req_arbiter #(.IN_WIDTH(c_IN_WIDTH), .OUT_WIDTH(c_OUT_WIDTH)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Registered arithmetic unit: returns {carry, result}
  function automatic logic [16:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] f);
    logic [16:0] r;
    r = '0;
    case (f)
      2'b00: r = {9'b0, a} + {9'b0, b};
      2'b01: r = {9'b0, a} - {9'b0, b};
      2'b10: r = {1'b0, {8'b0, a} * {8'b0, b}};
      default: begin
        if (b == 8'd0) r = 17'h1FFFF;
        else           r = {9'b0, a / b};
      end
    endcase
    return r;
  endfunction

  // Arithmetic unit model: result and flag appear the cycle after enable
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      bus.alu_out   <= '0;
      bus.alu_carry <= 1'b0;
      bus.alu_flag  <= 1'b0;
    end else begin
      bus.alu_flag <= bus.alu_enable;
      if (bus.alu_enable) begin
        {bus.alu_carry, bus.alu_out} <= alu_calc(bus.alu_A, bus.alu_B, bus.alu_fun);
      end
    end
  end

  // Count enable pulses seen by the unit
  always_ff @(posedge clk) begin
    if (bus.alu_enable === 1'b1) en_count <= en_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Entered in the handshake cycle (inputs already settled); leaves the bench
  // one cycle after the response, with rsp_ready assumed high.
  task automatic run_op(input string tag, input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] fun,
                        input logic [15:0] out, input logic carry, input logic err,
                        input bit drop);
    int en0;
    en0 = en_count;
    check({tag, "_grant"}, {bus.req1_ready, bus.req0_ready}, id ? 2'b10 : 2'b01);
    step();
    if (drop) begin
      if (id) bus.req1_valid = 1'b0;
      else    bus.req0_valid = 1'b0;
    end
    #1;
    check({tag, "_issue_en"}, {bus.alu_enable, bus.busy}, 2'b11);
    check({tag, "_operands"}, {bus.alu_fun, bus.alu_A, bus.alu_B}, {fun, a, b});
    check({tag, "_issue_rdy"}, {bus.req1_ready, bus.req0_ready}, 2'b00);
    step();
    check({tag, "_capture"}, {bus.alu_enable, bus.rsp_valid}, 2'b00);
    step();
    check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_err, bus.rsp_out},
          {1'b1, id, carry, err, out});
    check({tag, "_rsp_rdy"}, {bus.req1_ready, bus.req0_ready, bus.alu_enable}, 3'b000);
    step();
    check({tag, "_pulses"}, en_count - en0, 1);
    check({tag, "_idle"}, {bus.busy, bus.rsp_valid}, 2'b00);
  endtask

  initial begin
    RST           = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_fun = 2'b00;
    bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_fun = 2'b00;
    bus.rsp_ready  = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_alu", {bus.alu_enable, bus.alu_fun, bus.alu_A, bus.alu_B}, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_err, bus.rsp_out}, 0);
    check("rst_busy", bus.busy, 1'b0);
    RST = 1'b1;
    bus.rsp_ready = 1'b1;
    step();

    // Single requester 1: 5 + 3
    bus.req1_valid = 1'b1; bus.req1_A = 8'd5; bus.req1_B = 8'd3; bus.req1_fun = 2'b00;
    #1;
    run_op("single1", 1'b1, 8'd5, 8'd3, 2'b00, 16'd8, 1'b0, 1'b0, 1'b1);

    // Contention: both held valid, grants 0,1,0
    bus.req0_valid = 1'b1; bus.req0_A = 8'd200; bus.req0_B = 8'd100; bus.req0_fun = 2'b00;
    bus.req1_valid = 1'b1; bus.req1_A = 8'd12;  bus.req1_B = 8'd12;  bus.req1_fun = 2'b10;
    #1;
    run_op("cont0", 1'b0, 8'd200, 8'd100, 2'b00, 16'h012C, 1'b0, 1'b0, 1'b0);
    run_op("cont1", 1'b1, 8'd12,  8'd12,  2'b10, 16'h0090, 1'b0, 1'b0, 1'b0);
    run_op("cont2", 1'b0, 8'd200, 8'd100, 2'b00, 16'h012C, 1'b0, 1'b0, 1'b1);
    check("cont3_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    bus.req1_valid = 1'b0;
    #1;
    check("cont_quiet", {bus.req1_ready, bus.req0_ready}, 2'b00);

    // Divide by zero, then a normal divide
    bus.req0_valid = 1'b1; bus.req0_A = 8'd9; bus.req0_B = 8'd0; bus.req0_fun = 2'b11;
    #1;
    run_op("div0", 1'b0, 8'd9, 8'd0, 2'b11, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    bus.req0_valid = 1'b1; bus.req0_A = 8'd9; bus.req0_B = 8'd2; bus.req0_fun = 2'b11;
    #1;
    run_op("div", 1'b0, 8'd9, 8'd2, 2'b11, 16'h0004, 1'b0, 1'b0, 1'b1);

    // Backpressure: response held for 10 extra cycles while client 0 waits
    bus.rsp_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_A = 8'd7; bus.req1_B = 8'd6; bus.req1_fun = 2'b10;
    #1;
    check("bp_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_A = 8'd1; bus.req0_B = 8'd1; bus.req0_fun = 2'b00;
    #1;
    check("bp_issue_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
    step();
    step();
    check("bp_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_err, bus.rsp_out},
          {1'b1, 1'b1, 1'b0, 1'b0, 16'h002A});
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_carry, bus.rsp_err, bus.rsp_out},
            {1'b1, 1'b1, 1'b0, 1'b0, 16'h002A});
      check("bp_quiet", {bus.alu_enable, bus.req1_ready, bus.req0_ready, bus.busy}, 4'b0001);
    end
    bus.rsp_ready = 1'b1;
    step();
    run_op("bp_next", 1'b0, 8'd1, 8'd1, 2'b00, 16'd2, 1'b0, 1'b0, 1'b1);

    // Reset asserted during ISSUE
    bus.req1_valid = 1'b1; bus.req1_A = 8'd4; bus.req1_B = 8'd4; bus.req1_fun = 2'b00;
    #1;
    check("rm_grant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    step();
    check("rm_issue", bus.alu_enable, 1'b1);
    en_snap = en_count;
    RST = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rm_drop", {bus.alu_enable, bus.busy, bus.rsp_valid}, 3'b000);
    step();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rm_no_rsp", {bus.busy, bus.rsp_valid, bus.alu_enable}, 3'b000);
    end
    check("rm_no_pulse", en_count - en_snap, 0);
    bus.req0_valid = 1'b1; bus.req0_A = 8'd10; bus.req0_B = 8'd3; bus.req0_fun = 2'b01;
    bus.req1_valid = 1'b1; bus.req1_A = 8'd4;  bus.req1_B = 8'd4; bus.req1_fun = 2'b00;
    #1;
    run_op("rm_first",  1'b0, 8'd10, 8'd3, 2'b01, 16'd7, 1'b0, 1'b0, 1'b1);
    run_op("rm_second", 1'b1, 8'd4,  8'd4, 2'b00, 16'd8, 1'b0, 1'b0, 1'b1);

    // Subtract underflow
    bus.req1_valid = 1'b1; bus.req1_A = 8'd3; bus.req1_B = 8'd5; bus.req1_fun = 2'b01;
    #1;
    run_op("sub", 1'b1, 8'd3, 8'd5, 2'b01, 16'hFFFE, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
